// File: rtl/exmem_prefetch_if.sv
// Wishbone bundle between the CPU, the prefetch line buffer and the
// external-memory BRAM slave. Signal names keep the block-port view:
// *_i are driven into the prefetcher and *_o are driven by it.
interface exmem_prefetch_if;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic [31:0] wbm_dat_i;
  logic        wbm_ack_i;

  // Prefetcher side
  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o,
    output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
    input  wbm_dat_i, wbm_ack_i
  );

  // Environment side: CPU master plus memory slave
  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o,
    input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
    output wbm_dat_i, wbm_ack_i
  );
endinterface

// File: rtl/exmem_prefetch.sv
// Single-line read prefetch buffer in front of the external-memory BRAM.
// Read misses fill a whole line with single beats; writes go straight
// through and are merged into the line only when it is resident.
//
// state | meaning
// IDLE  | waiting for an upstream request; hits resolved here
// FILL  | fetching the line one beat at a time, one idle cycle after each ack
// WRITE | forwarding one write downstream
// RESP  | one-cycle upstream ack slot
module exmem_prefetch #(
  parameter int LINE_WORDS = 4
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  exmem_prefetch_if.slave bus,
  output logic [15:0]     hit_cnt_o
);
  localparam int IDX_W = $clog2(LINE_WORDS);
  localparam int TAG_W = 30 - IDX_W;
  localparam logic [IDX_W-1:0] LAST_BEAT = IDX_W'(LINE_WORDS - 1);

  typedef enum logic [1:0] {IDLE, FILL, WRITE, RESP} state_t;

  state_t            state_q, state_d;
  logic              valid_q, valid_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic [TAG_W-1:0]  req_tag_q, req_tag_d;
  logic [IDX_W-1:0]  req_idx_q, req_idx_d;
  logic [IDX_W-1:0]  beat_q, beat_d;
  logic              fill_done_q, fill_done_d;
  logic [31:0]       resp_dat_q, resp_dat_d;
  logic [15:0]       hit_cnt_q, hit_cnt_d;
  logic              wbm_cyc_q, wbm_cyc_d;
  logic              wbm_we_q, wbm_we_d;
  logic [3:0]        wbm_sel_q, wbm_sel_d;
  logic [31:0]       wbm_adr_q, wbm_adr_d;
  logic [31:0]       wbm_dat_q, wbm_dat_d;
  logic [31:0]       line_q [LINE_WORDS];
  logic [31:0]       line_d [LINE_WORDS];

  logic              req;
  logic              ack;
  logic [TAG_W-1:0]  in_tag;
  logic [IDX_W-1:0]  in_idx;

  assign req    = bus.wbs_cyc_i & bus.wbs_stb_i;
  assign in_tag = bus.wbs_adr_i[31:2+IDX_W];
  assign in_idx = bus.wbs_adr_i[1+IDX_W:2];

  // An upstream abort simply masks the ack slot; the FSM still passes through RESP.
  assign ack           = (state_q == RESP) & req;
  assign bus.wbs_ack_o = ack;
  assign bus.wbs_dat_o = ack ? resp_dat_q : 32'h0;

  assign bus.wbm_cyc_o = wbm_cyc_q;
  assign bus.wbm_stb_o = wbm_cyc_q;
  assign bus.wbm_we_o  = wbm_we_q;
  assign bus.wbm_sel_o = wbm_sel_q;
  assign bus.wbm_adr_o = wbm_adr_q;
  assign bus.wbm_dat_o = wbm_dat_q;
  assign hit_cnt_o     = hit_cnt_q;

  // Next-state, downstream beat sequencing and line buffer updates.
  always_comb begin
    state_d     = state_q;
    valid_d     = valid_q;
    tag_d       = tag_q;
    req_tag_d   = req_tag_q;
    req_idx_d   = req_idx_q;
    beat_d      = beat_q;
    fill_done_d = fill_done_q;
    resp_dat_d  = resp_dat_q;
    hit_cnt_d   = hit_cnt_q;
    wbm_cyc_d   = wbm_cyc_q;
    wbm_we_d    = wbm_we_q;
    wbm_sel_d   = wbm_sel_q;
    wbm_adr_d   = wbm_adr_q;
    wbm_dat_d   = wbm_dat_q;
    line_d      = line_q;

    case (state_q)
      IDLE: begin
        if (req) begin
          req_tag_d = in_tag;
          req_idx_d = in_idx;
          if (bus.wbs_we_i) begin
            wbm_cyc_d = 1'b1;
            wbm_we_d  = 1'b1;
            wbm_sel_d = bus.wbs_sel_i;
            wbm_adr_d = bus.wbs_adr_i;
            wbm_dat_d = bus.wbs_dat_i;
            state_d   = WRITE;
          end else if (valid_q && (tag_q == in_tag)) begin
            resp_dat_d = line_q[in_idx];
            if (hit_cnt_q != 16'hFFFF) hit_cnt_d = hit_cnt_q + 16'd1;
            state_d    = RESP;
          end else begin
            // The buffer is about to be overwritten, so it stops being valid now.
            valid_d     = 1'b0;
            beat_d      = '0;
            fill_done_d = 1'b0;
            wbm_cyc_d   = 1'b1;
            wbm_we_d    = 1'b0;
            wbm_sel_d   = 4'hF;
            wbm_adr_d   = {in_tag, {IDX_W{1'b0}}, 2'b00};
            state_d     = FILL;
          end
        end
      end
      FILL: begin
        if (wbm_cyc_q) begin
          if (bus.wbm_ack_i) begin
            line_d[beat_q] = bus.wbm_dat_i;
            wbm_cyc_d      = 1'b0;
            if (beat_q == LAST_BEAT) fill_done_d = 1'b1;
            else                     beat_d      = beat_q + 1'b1;
          end
        end else if (fill_done_q) begin
          // The idle cycle after the last ack is the extra cycle of miss latency.
          valid_d    = 1'b1;
          tag_d      = req_tag_q;
          resp_dat_d = line_q[req_idx_q];
          wbm_sel_d  = 4'h0;
          state_d    = RESP;
        end else begin
          wbm_cyc_d = 1'b1;
          wbm_adr_d = {req_tag_q, beat_q, 2'b00};
        end
      end
      WRITE: begin
        if (bus.wbm_ack_i) begin
          wbm_cyc_d = 1'b0;
          wbm_we_d  = 1'b0;
          if (valid_q && (tag_q == req_tag_q)) begin
            for (int b = 0; b < 4; b++) begin
              if (wbm_sel_q[b]) line_d[req_idx_q][8*b +: 8] = wbm_dat_q[8*b +: 8];
            end
          end
          resp_dat_d = 32'h0;
          state_d    = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and bus registers; reset abandons any downstream transaction.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q     <= IDLE;
      valid_q     <= 1'b0;
      tag_q       <= '0;
      req_tag_q   <= '0;
      req_idx_q   <= '0;
      beat_q      <= '0;
      fill_done_q <= 1'b0;
      resp_dat_q  <= 32'h0;
      hit_cnt_q   <= 16'h0;
      wbm_cyc_q   <= 1'b0;
      wbm_we_q    <= 1'b0;
      wbm_sel_q   <= 4'h0;
      wbm_adr_q   <= 32'h0;
      wbm_dat_q   <= 32'h0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      tag_q       <= tag_d;
      req_tag_q   <= req_tag_d;
      req_idx_q   <= req_idx_d;
      beat_q      <= beat_d;
      fill_done_q <= fill_done_d;
      resp_dat_q  <= resp_dat_d;
      hit_cnt_q   <= hit_cnt_d;
      wbm_cyc_q   <= wbm_cyc_d;
      wbm_we_q    <= wbm_we_d;
      wbm_sel_q   <= wbm_sel_d;
      wbm_adr_q   <= wbm_adr_d;
      wbm_dat_q   <= wbm_dat_d;
    end
  end

  // Line storage is qualified by valid, so it needs no reset.
  always_ff @(posedge wb_clk_i) begin
    line_q <= line_d;
  end
endmodule

// File: doc/exmem_prefetch.md
EXMEM_PREFETCH -- requirements
Module: exmem_prefetch

Interface
REQ-001 SHALL have parameter LINE_WORDS, default 4, meaning words per line buffer; legal values 2, 4, 8.
REQ-002 SHALL have port wb_clk_i  input  1  clock; single clock domain, all logic on its rising edge.
REQ-003 SHALL have port wb_rst_i  input  1  reset, synchronous, active-high.
REQ-004 SHALL have upstream slave ports wbs_cyc_i, wbs_stb_i, wbs_we_i  input  1 each  Wishbone request qualifiers from CPU.
REQ-005 SHALL have wbs_sel_i  input  4  byte enables; wbs_adr_i  input  32  byte address; wbs_dat_i  input  32  write data.
REQ-006 SHALL have wbs_ack_o  output  1  upstream ack; wbs_dat_o  output  32  upstream read data.
REQ-007 SHALL have downstream master ports wbm_cyc_o, wbm_stb_o, wbm_we_o  output  1 each; wbm_sel_o  output  4; wbm_adr_o  output  32; wbm_dat_o  output  32; feed the external-memory BRAM slave.
REQ-008 SHALL have wbm_dat_i  input  32  downstream read data; wbm_ack_i  input  1  downstream ack.
REQ-009 SHALL have hit_cnt_o  output  16  count of read hits.

Function
REQ-010 SHALL hold one line buffer of LINE_WORDS x 32 bits, a tag (wbs_adr_i[31:2+log2(LINE_WORDS)]), and a valid bit.
REQ-011 SHALL implement states IDLE, FILL, WRITE, RESP; the request is sampled only in IDLE when wbs_cyc_i && wbs_stb_i.
REQ-012 Read hit (valid && tag match) in IDLE: SHALL assert wbs_ack_o exactly one cycle later with the buffered word on wbs_dat_o; no downstream traffic; hit_cnt_o increments.
REQ-013 Read miss: IDLE->FILL; SHALL issue LINE_WORDS single reads at line base, base+4, ..., in ascending order, wbm_we_o=0, wbm_sel_o=4'hF.
REQ-014 Each downstream beat SHALL hold wbm_cyc_o, wbm_stb_o, wbm_adr_o stable until wbm_ack_i, then deassert cyc/stb for exactly one cycle before the next beat.
REQ-015 SHALL capture wbm_dat_i into the buffer word indexed by the beat in the cycle wbm_ack_i is high.
REQ-016 After the last beat ack, SHALL set valid, load tag, go to RESP; RESP SHALL assert wbs_ack_o for one cycle with the requested word, then return to IDLE.
REQ-017 Write (any wbs_sel_i): IDLE->WRITE; SHALL forward one downstream write with identical adr/sel/dat (write-through, no allocate).
REQ-018 On write ack, if valid && tag match, SHALL merge enabled bytes into the buffer word; go to RESP and ack upstream one cycle later.
REQ-019 wbs_ack_o SHALL be a single-cycle pulse and SHALL be suppressed if wbs_cyc_i or wbs_stb_i is low in RESP/hit cycle (upstream abort).
REQ-020 Upstream abort during FILL or WRITE: downstream sequence SHALL complete; a completed fill SHALL still mark the line valid.
REQ-021 Line-buffer wrap: word index SHALL be wbs_adr_i[1+log2(LINE_WORDS):2]; the last word of a line and the first of the next line are distinct tags.
REQ-022 hit_cnt_o SHALL saturate at 16'hFFFF.
REQ-023 wbs_dat_o SHALL be 0 when wbs_ack_o is low.
REQ-024 Total miss latency SHALL be LINE_WORDS x (downstream latency + 1) + 1 cycles from request sample to wbs_ack_o.

Reset
REQ-025 On wb_rst_i high at a clock edge: state=IDLE, valid=0, hit_cnt_o=0, wbs_ack_o=0, wbs_dat_o=0, all wbm_* outputs 0; buffer contents need not be cleared.
REQ-026 Reset asserted mid-FILL or mid-WRITE SHALL abandon the transaction immediately, dropping wbm_cyc_o/wbm_stb_o the next cycle; line stays invalid.

Verification
REQ-027 Read 0x3800_0010 after reset, downstream model acking at 11th cycle of stb -> 4 downstream reads 0x...10, 14, 18, 1C with one idle cycle between; ack with word 0 after 4x12+1 cycles; hit_cnt_o=0.
REQ-028 Then read 0x3800_0018 -> ack one cycle later, data = word 2 of fill, no wbm_stb_o activity, hit_cnt_o=1.
REQ-029 Write 0x3800_0014 data 0xAABBCCDD sel 4'b0011 to valid line -> one downstream write same fields; subsequent read 0x3800_0014 hits returning old[31:16] merged with 0xCCDD.
REQ-030 Write to 0x3800_0100 (non-resident) -> downstream write only; read 0x3800_0010 still hits.
REQ-031 Drop wbs_cyc_i in 3rd fill beat -> fill completes, no wbs_ack_o; re-read same address hits.
REQ-032 Assert wb_rst_i during 2nd fill beat -> wbm_cyc_o=0 next cycle, all outputs 0; next read of same line misses.
